// File: rtl/snake_move_ctrl.sv
// Snake move scheduler: one move request per game tick, request held until move_ack.
// Request registers on the cycle after the terminal count; ate_food shortens the tick period.
module snake_move_ctrl #(
  parameter int unsigned TICK_DIV_INIT = 5000000,
  parameter int unsigned TICK_DIV_MIN  = 1000000,
  parameter int unsigned TICK_DIV_STEP = 250000,
  parameter int unsigned CNT_W         = 24
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_init_snake,
  input  logic       i_screen_pause,
  input  logic       i_screen_black,
  input  logic [7:0] i_key_code,
  input  logic       i_ate_food,
  input  logic       i_move_ack,
  output logic       o_move_req,
  output logic [1:0] o_move_dir,
  output logic       o_grow,
  output logic [3:0] o_speed_level
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_REQ   = 2'd2;

  localparam logic [CNT_W-1:0] P_INIT = CNT_W'(TICK_DIV_INIT);
  localparam logic [CNT_W-1:0] P_MIN  = CNT_W'(TICK_DIV_MIN);
  localparam logic [CNT_W-1:0] P_STEP = CNT_W'(TICK_DIV_STEP);
  localparam logic [CNT_W-1:0] P_ONE  = CNT_W'(1);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [1:0]       r_cur_dir;
  logic [1:0]       r_pend_dir;
  logic             r_grow_pend;
  logic [3:0]       r_speed_level;
  logic             r_move_req;
  logic [1:0]       r_move_dir;
  logic             r_grow;

  logic             w_key_vld;
  logic [1:0]       w_key_dir;
  logic             w_key_ok;
  logic             w_term;
  logic [CNT_W-1:0] w_period_dec;

  always_comb begin
    w_key_vld = 1'b1;
    w_key_dir = DIR_RIGHT;
    case (i_key_code)
      8'h75:   w_key_dir = DIR_UP;
      8'h74:   w_key_dir = DIR_RIGHT;
      8'h72:   w_key_dir = DIR_DOWN;
      8'h6B:   w_key_dir = DIR_LEFT;
      default: w_key_vld = 1'b0;
    endcase
  end

  // Opposite directions differ by exactly 2 in this encoding.
  assign w_key_ok     = w_key_vld && ((w_key_dir ^ r_cur_dir) != 2'd2);
  // >= so a period shrunk below the running count fires on the next cycle.
  assign w_term       = (r_cnt >= (r_period - P_ONE));
  assign w_period_dec = ((r_period - P_MIN) >= P_STEP) ? (r_period - P_STEP) : P_MIN;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_init_snake) begin
      r_state       <= i_reset ? S_IDLE : S_COUNT;
      r_cnt         <= '0;
      r_period      <= P_INIT;
      r_cur_dir     <= DIR_RIGHT;
      r_pend_dir    <= DIR_RIGHT;
      r_grow_pend   <= 1'b0;
      r_speed_level <= 4'd0;
      r_move_req    <= 1'b0;
      r_move_dir    <= DIR_RIGHT;
      r_grow        <= 1'b0;
    end else if (i_screen_black) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_move_req <= 1'b0;
      r_grow     <= 1'b0;
    end else begin
      if (w_key_ok && !i_screen_pause) begin
        r_pend_dir <= w_key_dir;
      end
      case (r_state)
        S_IDLE: ;
        S_COUNT: begin
          if (!i_screen_pause) begin
            if (w_term) begin
              r_cnt      <= '0;
              r_state    <= S_REQ;
              r_move_req <= 1'b1;
              r_move_dir <= r_pend_dir;
              r_cur_dir  <= r_pend_dir;
              r_grow     <= r_grow_pend;
            end else begin
              r_cnt <= r_cnt + P_ONE;
            end
          end
        end
        S_REQ: begin
          if (i_move_ack) begin
            r_move_req  <= 1'b0;
            r_grow      <= 1'b0;
            r_grow_pend <= 1'b0;
            r_cnt       <= '0;
            r_state     <= S_COUNT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Placed after the ack handling so food eaten in the ack cycle still grows the next move.
      if (i_ate_food && (r_state != S_IDLE)) begin
        r_grow_pend <= 1'b1;
        r_period    <= w_period_dec;
        if (r_speed_level != 4'hF) begin
          r_speed_level <= r_speed_level + 4'd1;
        end
      end
    end
  end

  assign o_move_req    = r_move_req;
  assign o_move_dir    = r_move_dir;
  assign o_grow        = r_grow;
  assign o_speed_level = r_speed_level;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Scoreboard bench for snake_move_ctrl with INIT=8, MIN=4, STEP=2.
// Cycle n is the interval after the n-th rising edge; inputs change and outputs are sampled on falling edges.
module tb_snake_move_ctrl;

  logic       clk;
  logic       reset;
  logic       init_snake;
  logic       screen_pause;
  logic       screen_black;
  logic [7:0] key_code;
  logic       ate_food;
  logic       move_ack;
  logic       move_req;
  logic [1:0] move_dir;
  logic       grow;
  logic [3:0] speed_level;

  snake_move_ctrl #(
    .TICK_DIV_INIT(8),
    .TICK_DIV_MIN (4),
    .TICK_DIV_STEP(2),
    .CNT_W        (8)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_init_snake  (init_snake),
    .i_screen_pause(screen_pause),
    .i_screen_black(screen_black),
    .i_key_code    (key_code),
    .i_ate_food    (ate_food),
    .i_move_ack    (move_ack),
    .o_move_req    (move_req),
    .o_move_dir    (move_dir),
    .o_grow        (grow),
    .o_speed_level (speed_level)
  );

  typedef struct {
    int         cyc;
    logic [1:0] dir;
    logic       grw;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc;
  int   n_chk;
  int   n_pass;
  int   t;
  logic prev_req;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input int c, input logic [1:0] d, input logic g);
    exp_t e;
    e.cyc = c;
    e.dir = d;
    e.grw = g;
    sb.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_init();
    init_snake = 1'b1;
    @(negedge clk);
    init_snake = 1'b0;
  endtask

  // Monitor: every rising edge of move_req is matched against the next expected move.
  initial prev_req = 1'b0;
  always @(negedge clk) begin
    if (move_req && !prev_req) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_req: got move_req=1 expected none (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("req_cycle", cyc, mon_e.cyc);
        chk("req_dir", int'(move_dir), int'(mon_e.dir));
        chk("req_grow", int'(grow), int'(mon_e.grw));
      end
    end
    prev_req = move_req;
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b1;
    init_snake = 1'b0;
    screen_pause = 1'b0;
    screen_black = 1'b0;
    key_code = 8'h00;
    ate_food = 1'b0;
    move_ack = 1'b1;
    @(negedge clk);
    goto(2);
    chk("rst_req", int'(move_req), 0);
    chk("rst_dir", int'(move_dir), 1);
    chk("rst_grow", int'(grow), 0);
    chk("rst_speed", int'(speed_level), 0);
    reset = 1'b0;

    // Basic tick timing and direction capture with reverse rejection.
    goto(6);
    t = cyc;
    push(t + 9, 1, 0);
    push(t + 18, 1, 0);
    push(t + 27, 1, 0);
    push(t + 36, 0, 0);
    push(t + 45, 1, 0);
    pulse_init();
    goto(t + 19); key_code = 8'h6B;
    goto(t + 21); key_code = 8'h00;
    goto(t + 28); key_code = 8'h75;
    goto(t + 30); key_code = 8'h00;
    goto(t + 37); key_code = 8'h72;
    goto(t + 38); key_code = 8'h74;
    goto(t + 40); key_code = 8'h00;
    goto(t + 47);

    // Speed-ups: period 8 -> 6 -> 4 -> 4, last pulse lands in the ack cycle.
    t = cyc;
    push(t + 7, 1, 1);
    push(t + 14, 1, 0);
    push(t + 19, 1, 1);
    push(t + 24, 1, 1);
    push(t + 29, 1, 0);
    pulse_init();
    goto(t + 2);  ate_food = 1'b1;
    goto(t + 3);  ate_food = 1'b0;
    goto(t + 16); ate_food = 1'b1;
    goto(t + 17); ate_food = 1'b0;
    goto(t + 19); ate_food = 1'b1;
    goto(t + 20); ate_food = 1'b0;
    goto(t + 25);
    chk("speed_sat3", int'(speed_level), 3);
    goto(t + 31);

    // Pause freezes the tick; pause during an unacked request holds it.
    t = cyc;
    push(t + 29, 1, 0);
    push(t + 43, 1, 0);
    pulse_init();
    goto(t + 4);  screen_pause = 1'b1;
    goto(t + 24); screen_pause = 1'b0;
    goto(t + 25); move_ack = 1'b0;
    goto(t + 30); screen_pause = 1'b1;
    for (int c = 30; c <= 34; c++) begin
      goto(t + c);
      chk("pause_req_hold", int'(move_req), 1);
    end
    move_ack = 1'b1;
    screen_pause = 1'b0;
    goto(t + 35);
    chk("pause_ack_drop", int'(move_req), 0);
    goto(t + 46);

    // Delayed ack with stable outputs, ate_food in the ack cycle, then blank screen.
    t = cyc;
    move_ack = 1'b0;
    push(t + 7, 0, 1);
    push(t + 17, 0, 1);
    push(t + 22, 0, 0);
    push(t + 27, 0, 0);
    pulse_init();
    goto(t + 2); key_code = 8'h75;
    goto(t + 3); key_code = 8'h00; ate_food = 1'b1;
    goto(t + 4); ate_food = 1'b0;
    for (int c = 7; c <= 12; c++) begin
      goto(t + c);
      if (c == 12) begin
        move_ack = 1'b1;
        ate_food = 1'b1;
      end
      chk("stall_req", int'(move_req), 1);
      chk("stall_dir", int'(move_dir), 0);
      chk("stall_grow", int'(grow), 1);
    end
    goto(t + 13);
    ate_food = 1'b0;
    chk("ack_req_drop", int'(move_req), 0);
    chk("ack_grow_drop", int'(grow), 0);
    goto(t + 23); move_ack = 1'b0;
    goto(t + 29); screen_black = 1'b1;
    goto(t + 30);
    screen_black = 1'b0;
    move_ack = 1'b1;
    chk("black_req", int'(move_req), 0);
    chk("black_speed", int'(speed_level), 2);
    goto(t + 40);
    chk("black_idle", int'(move_req), 0);

    // Reset mid-count restores reset values; a fresh init times like the first one.
    t = cyc;
    push(t + 7, 0, 1);
    pulse_init();
    goto(t + 1); key_code = 8'h75;
    goto(t + 2); key_code = 8'h00; ate_food = 1'b1;
    goto(t + 3); ate_food = 1'b0;
    goto(t + 10); reset = 1'b1;
    goto(t + 11);
    reset = 1'b0;
    chk("mid_rst_req", int'(move_req), 0);
    chk("mid_rst_dir", int'(move_dir), 1);
    chk("mid_rst_grow", int'(grow), 0);
    chk("mid_rst_speed", int'(speed_level), 0);
    goto(t + 14);
    t = cyc;
    push(t + 9, 1, 0);
    push(t + 18, 1, 0);
    pulse_init();
    goto(t + 21);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/snake_move_ctrl.md
Name: snake_move_ctrl

Overview:
- Move scheduler for the snake body datapath. Issues one move request per game tick, carrying the latched direction and a grow flag.
- Driven by the game-state controls init_snake, screen_pause and screen_black, and by the PS/2 key_code byte.
- Handshakes each move with the body datapath (move_req/move_ack).
- Speeds the game up each time food is eaten, saturating at a minimum tick period.

Parameters:
TICK_DIV_INIT, 5000000, clock cycles per tick after reset or init; must be >= TICK_DIV_MIN.
TICK_DIV_MIN, 1000000, minimum tick period in cycles; must be >= 2.
TICK_DIV_STEP, 250000, cycles removed from the period per ate_food pulse.
CNT_W, 24, width of the tick counter and period register; must hold TICK_DIV_INIT.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
init_snake  input  1  level; restart the game (from game-state FSM).
screen_pause  input  1  level; pause or game-over freeze.
screen_black  input  1  level; game not running.
key_code  input  8  current PS/2 scan code, level-held.
ate_food  input  1  one-cycle pulse from the body datapath.
move_ack  input  1  body datapath accepted the current move.
move_req  output  1  move request, held until acknowledged.
move_dir  output  2  0 up, 1 right, 2 down, 3 left; valid while move_req.
grow  output  1  this move lengthens the snake; valid while move_req.
speed_level  output  4  number of speed-ups applied, saturating at 15.

Behaviour:
- Internal state: IDLE, COUNT, REQ. Registers: cnt, period, cur_dir, pend_dir, grow_pend, speed_level.
- Reset values:
  - state IDLE; move_req 0; move_dir 1; grow 0; speed_level 0.
  - cnt 0; period TICK_DIV_INIT; cur_dir 1; pend_dir 1; grow_pend 0.
- Priority: reset > init_snake > screen_black > normal operation.
- init_snake high:
  - Load the reset values, except state goes to COUNT.
  - Any outstanding request is aborted: move_req is 0 the next cycle.
- screen_black high: state IDLE, cnt 0, move_req 0. period, directions, grow_pend and speed_level are held.
- IDLE: only init_snake leaves IDLE.
- COUNT:
  - If screen_pause is high, cnt holds (the tick freezes, it is not restarted).
  - Otherwise cnt increments by one per cycle.
  - When cnt == period-1 and not paused: cnt goes to 0, state goes to REQ, and the following outputs register together:
    - move_req = 1;
    - move_dir = pend_dir, and cur_dir = pend_dir;
    - grow = grow_pend.
  - With TICK_DIV_INIT=8, move_req is high exactly 9 cycles after the init_snake cycle.
- REQ:
  - move_req, move_dir and grow stay stable until move_ack is sampled high.
  - screen_pause does not abort a request; the handshake completes.
  - On ack: move_req = 0 and grow = 0 the next cycle, state returns to COUNT with cnt = 0, and grow_pend is cleared.
  - ate_food in the same cycle as the ack leaves grow_pend = 1.
  - With an immediate ack, request rising edges are period+1 cycles apart.
  - move_ack while move_req = 0 is ignored.
- Direction capture (only while not paused and not black):
  - key 8'h75 → up, 8'h74 → right, 8'h72 → down, 8'h6B → left.
  - pend_dir updates only if the new direction is not the reverse of cur_dir (new XOR cur_dir != 2).
  - Several keys within one tick: the last valid key wins.
  - All other codes (including 8'h1B, 8'h76, 8'h4D, 8'h2D) are ignored.
- ate_food pulse (accepted in any state except IDLE):
  - grow_pend = 1.
  - period = max(period - TICK_DIV_STEP, TICK_DIV_MIN), with no underflow.
  - speed_level increments, saturating at 15.
  - The new period takes effect on the next terminal-count comparison; a tick already in progress compares against the new value.
  - If cnt >= new period-1, the terminal condition fires on the next cycle.

Test Plan (INIT=8, MIN=4, STEP=2, move_ack tied high unless stated):
1. Reset, then one-cycle init_snake → move_req high at init+9 cycles with move_dir=1, grow=0; next request edge 9 cycles later.
2. key_code 8'h6B while cur_dir=1 → move_dir stays 1. Then key_code 8'h75 → next move has move_dir=0. Then 8'h72 → ignored (reverse); 8'h74 → next move_dir=1.
3. Three ate_food pulses in separate cycles → period 6, 4, 4; speed_level=3; grow=1 on the next move only, then 0.
4. screen_pause asserted when cnt=3, held 20 cycles → no move_req during the pause. After release, move_req rises 5 cycles later. Pause asserted while move_req is high with ack low → move_req holds.
5. move_ack delayed 5 cycles → move_req, move_dir and grow stable for all 5 cycles and drop the cycle after the ack. ate_food in the ack cycle → next move grow=1.
6. screen_black mid-REQ → move_req 0 next cycle, state IDLE, speed_level retained. reset mid-COUNT → all outputs at reset values next cycle. init_snake afterwards → timing identical to scenario 1, period 8.
